serial_adder: RTL and testbench

//   Bit-serial ripple adder, LSB-first: {cout,sum} = a + b + cin over WIDTH clocks

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// The controller drives the request side and the adder drives the result side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a carry flip-flop
// produces {cout,sum} = a + b + cin over WIDTH clocks behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic             w_ai;
    logic             w_bi;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sumNext;

    assign w_ai = r_a[0];
    assign w_bi = r_b[0];
    assign w_s  = w_ai ^ w_bi ^ r_carry;
    assign w_c  = (w_ai & w_bi) | (r_carry & (w_ai ^ w_bi));

    // New sum bit enters at the MSB so the LSB-first stream ends up in place after WIDTH shifts.
    always_comb begin
        w_sumNext            = r_sum >> 1;
        w_sumNext[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sumNext;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_BIT) begin
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for handshake, abort and
// back-to-back scenarios, plus a 1-bit instance for the degenerate width and a random sweep.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [8:0] exp8 [$];
    logic [1:0] exp1 [$];

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request on the 8-bit instance at a falling edge and records the model result.
    task automatic startAdd8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit push);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
        if (push) exp8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
    endtask

    // Watches the 8-bit instance after an accepted start; optionally re-asserts start mid-run.
    task automatic runWatch8(input int maxCyc, input int restartAt, output int doneIdx,
                             output int busyCnt, output int doneCnt, output int overlap,
                             output logic [8:0] res);
        doneIdx = -1;
        busyCnt = 0;
        doneCnt = 0;
        overlap = 0;
        res     = '0;
        @(posedge clk);
        for (int i = 1; i <= maxCyc; i++) begin
            @(negedge clk);
            if (bus8.busy) busyCnt++;
            if (bus8.busy && bus8.done) overlap++;
            if (bus8.done) begin
                doneCnt++;
                if (doneIdx < 0) begin
                    doneIdx = i;
                    res     = {bus8.cout, bus8.sum};
                end
            end
            if (i == 1) begin
                bus8.start = 1'b0;
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
                bus8.cin   = 1'($urandom);
            end
            if (restartAt > 0 && i == restartAt) begin
                bus8.start = 1'b1;
                bus8.a     = 8'h11;
            end
            if (restartAt > 0 && i == restartAt + 1) bus8.start = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus8.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus8.done); end
        if (bus8.sum !== 8'h00) begin failures++; $display("[TB] FAIL reset_sum: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout: got %b expected 0", bus8.cout); end
        if (bus1.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_w1: got %b expected 0", bus1.busy); end
        if ({bus1.done, bus1.cout, bus1.sum} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_outs_w1: got %b expected 000", {bus1.done, bus1.cout, bus1.sum});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int dIdx, bCnt, dCnt, ovl;
        logic [8:0] res, exp;
        startAdd8(8'h5A, 8'h3C, 1'b0, 1'b1);
        runWatch8(14, 0, dIdx, bCnt, dCnt, ovl, res);
        exp = (exp8.size() > 0) ? exp8.pop_front() : 9'bx;
        checks += 6;
        if (dIdx !== 9) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 9", dIdx); end
        if (bCnt !== 8) begin failures++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bCnt); end
        if (dCnt !== 1) begin failures++; $display("[TB] FAIL basic_done_count: got %0d expected 1", dCnt); end
        if (ovl !== 0) begin failures++; $display("[TB] FAIL basic_busy_done_overlap: got %0d expected 0", ovl); end
        if (res !== exp) begin failures++; $display("[TB] FAIL basic_result: got %h expected %h", res, exp); end
        if (res !== 9'h096) begin failures++; $display("[TB] FAIL basic_const: got %h expected 096", res); end
    endtask

    task automatic test_carry;
        int dIdx, bCnt, dCnt, ovl;
        logic [8:0] res, exp;
        startAdd8(8'hFF, 8'h01, 1'b0, 1'b1);
        runWatch8(12, 0, dIdx, bCnt, dCnt, ovl, res);
        exp = (exp8.size() > 0) ? exp8.pop_front() : 9'bx;
        checks += 2;
        if (res !== exp) begin failures++; $display("[TB] FAIL carry_ripple: got %h expected %h", res, exp); end
        if (dIdx !== 9) begin failures++; $display("[TB] FAIL carry_ripple_latency: got %0d expected 9", dIdx); end
        startAdd8(8'hFF, 8'hFF, 1'b1, 1'b1);
        runWatch8(12, 0, dIdx, bCnt, dCnt, ovl, res);
        exp = (exp8.size() > 0) ? exp8.pop_front() : 9'bx;
        checks += 2;
        if (res !== exp) begin failures++; $display("[TB] FAIL carry_all_ones: got %h expected %h", res, exp); end
        if (res !== 9'h1FF) begin failures++; $display("[TB] FAIL carry_all_ones_const: got %h expected 1ff", res); end
    endtask

    task automatic test_ignore_start;
        int dIdx, bCnt, dCnt, ovl;
        logic [8:0] res, exp;
        startAdd8(8'h23, 8'h45, 1'b1, 1'b1);
        runWatch8(16, 3, dIdx, bCnt, dCnt, ovl, res);
        exp = (exp8.size() > 0) ? exp8.pop_front() : 9'bx;
        checks += 4;
        if (res !== exp) begin failures++; $display("[TB] FAIL ignore_result: got %h expected %h", res, exp); end
        if (dCnt !== 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dCnt); end
        if (dIdx !== 9) begin failures++; $display("[TB] FAIL ignore_latency: got %0d expected 9", dIdx); end
        if (bCnt !== 8) begin failures++; $display("[TB] FAIL ignore_busy_cycles: got %0d expected 8", bCnt); end
    endtask

    task automatic test_abort;
        int dCnt;
        startAdd8(8'hFF, 8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus8.start = 1'b0;
        end
        checks++;
        if (bus8.busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b expected 1", bus8.busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (bus8.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", bus8.busy); end
        if (bus8.done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done: got %b expected 0", bus8.done); end
        if (bus8.sum !== 8'h00) begin failures++; $display("[TB] FAIL abort_sum: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL abort_cout: got %b expected 0", bus8.cout); end
        dCnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) dCnt++;
        end
        checks++;
        if (dCnt !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", dCnt); end
    endtask

    task automatic test_back_to_back;
        int prev, got, ovl;
        logic [8:0] exp;
        prev = 0;
        got  = 0;
        ovl  = 0;
        startAdd8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        @(posedge clk);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus8.busy && bus8.done) ovl++;
            if (bus8.done) begin
                exp = (exp8.size() > 0) ? exp8.pop_front() : 9'bx;
                checks += 2;
                if (i - prev !== 9) begin failures++; $display("[TB] FAIL b2b_interval: got %0d expected 9", i - prev); end
                if ({bus8.cout, bus8.sum} !== exp) begin
                    failures++; $display("[TB] FAIL b2b_result: got %h expected %h", {bus8.cout, bus8.sum}, exp);
                end
                prev = i;
                got++;
                if (got < 5) startAdd8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
                else bus8.start = 1'b0;
            end
        end
        bus8.start = 1'b0;
        checks += 2;
        if (got !== 5) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 5", got); end
        if (ovl !== 0) begin failures++; $display("[TB] FAIL b2b_overlap: got %0d expected 0", ovl); end
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        logic a, b, c;
        for (int n = 0; n <= 1000; n++) begin
            if (n == 0) begin a = 1'b1; b = 1'b1; c = 1'b1; end
            else begin a = 1'($urandom); b = 1'($urandom); c = 1'($urandom); end
            bus1.a     = a;
            bus1.b     = b;
            bus1.cin   = c;
            bus1.start = 1'b1;
            exp1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            if (n == 0) begin
                checks++;
                if (bus1.busy !== 1'b1) begin failures++; $display("[TB] FAIL w1_busy: got %b expected 1", bus1.busy); end
            end
            @(negedge clk);
            exp = (exp1.size() > 0) ? exp1.pop_front() : 2'bx;
            checks += 2;
            if (bus1.done !== 1'b1) begin failures++; $display("[TB] FAIL w1_done_latency vec %0d: got %b expected 1", n, bus1.done); end
            if ({bus1.cout, bus1.sum} !== exp) begin
                failures++; $display("[TB] FAIL w1_result vec %0d: got %b expected %b", n, {bus1.cout, bus1.sum}, exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
